hsv2rgb_sector: RTL and testbench
=================================

// Module: hsv2rgb_sector
// PURPOSE
// - Inverse of the hue sector selector: rebuilds R,G,B from H,S,V in the same Q16.15 sign-magnitude format.
// - H is in sextant units [0,6). Its integer part selects the sector; its fraction f weights the ramp colour.
// - Computes p=V(1-S), q=V(1-Sf), t=V(1-S(1-f)), then routes {V,p,q,t} to R/G/B by sector.
// - 4-stage pipeline with valid/ready on both sides. Sits after the HSV adjust stage, before pixel pack.
// PARAMETERS
// - N     32  word width; bit N-1 = sign, bits N-2:15 = integer part, bits 14:0 = fraction
// - FRAC  15  fractional bits; ONE = 1<<FRAC = 0x8000
// PORTS
// - clk        in   1  single clock; all state on rising edge
// - rst        in   1  asynchronous, active-high reset
// - in_valid   in   1  H/S/V valid this cycle
// - in_ready   out  1  block accepts H/S/V this cycle
// - H          in   N  hue, sextants, Q16.15 sign-magnitude
// - S          in   N  saturation, Q16.15, nominal [0,ONE]
// - V          in   N  value, Q16.15, nominal [0,ONE]
// - out_valid  out  1  R/G/B/out_err valid
// - out_ready  in   1  consumer accepts outputs
// - R,G,B      out  N  Q16.15, sign bit always 0
// - out_err    out  1  hue out of range for this pixel
// BEHAVIOUR
// - Reset (async, any time, including mid-stream): all stage valids=0, out_valid=0, R=G=B=0, out_err=0.
//   In-flight pixels are discarded. in_ready=1 from the first cycle after reset deasserts.
// - Global advance en = !out_valid | out_ready. in_ready = en.
//   Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
// - en=0 freezes every stage register, data and valid. No bubble compression.
//   Latency is 4 cycles with no stalls. Throughput is 1 pixel/cycle. Order is preserved. No drop, no duplicate.
// - S1 (decode):
//   - sec = H[N-2:FRAC]; f = {1'b0,H[FRAC-1:0]}.
//   - err = H[N-1] | (sec>=6).
//   - S and V: magnitude clamped to ONE if > ONE; sign bit ignored.
// - S2: a = (S*f)>>FRAC; b = (S*(ONE-f))>>FRAC.
//   - Unsigned 17x17 multiply, truncating shift (no rounding).
// - S3: p = (V*(ONE-S))>>FRAC; q = (V*(ONE-a))>>FRAC; t = (V*(ONE-b))>>FRAC.
//   - All operands <= ONE, so results <= ONE. No overflow possible.
// - S4 (route, registered outputs):
//   sec  0:(V,t,p)  1:(q,V,p)  2:(p,V,t)  3:(p,q,V)  4:(t,p,V)  5:(V,p,q)  as (R,G,B)
// - err=1: R=G=B=0, out_err=1, still one valid output per accepted input.
// - Boundaries:
//   - f=0 at a sector edge gives exact primaries.
//   - H=6.0 is an error; no wrap to 0.
//   - S=0 gives R=G=B=V.
//   - V=0 gives all 0.
// - Outputs are held stable while out_valid & !out_ready.
// STRUCTURE
// - Package hsv_pkg holds N, FRAC, ONE, NSEC=6, the sector encoding, and the Q16.15 field-slice macros.
//   The forward selector reuses the same package.
// - Sub-module q15_mul: unsigned (a*b)>>FRAC on 17-bit magnitudes. Five instances: 2 in S2, 3 in S3.
// - Sector routing is a case statement in S4. Stage regs use one shared en.
// TESTING
// - H=0, S=ONE, V=ONE
//   -> after 4 clk: R=0x8000, G=0, B=0, out_err=0.
// - H=0x10000 (2.0), S=ONE, V=ONE
//   -> R=0, G=0x8000, B=0.
//   H=0x20000 (4.0) -> R=0, G=0, B=0x8000.
// - H=0xC000 (1.5), S=ONE, V=ONE
//   -> R=0x4000, G=0x8000, B=0.
//   H=0x28000 (5.0) -> R=0x8000, G=0, B=0x8000.
// - S=0, V=0x4000, H=0x18000
//   -> R=G=B=0x4000.
//   S=0x9000 clamps: same result as S=ONE.
// - H=0x30000 (6.0) or H=0x80004000 (sign set)
//   -> out_err=1, R=G=B=0, out_valid pulses once.
// - Backpressure: stream 6 pixels back-to-back, out_ready=0 for 5 cycles mid-stream
//   -> in_ready=0 while stalled, outputs stable, all 6 emerge in order.
//   Assert rst mid-stream -> out_valid=0 immediately, no stale output afterwards.

Source files
------------

// File: rtl/hsv2rgb_sector_pkg.sv
// Shared Q16.15 HSV definitions: word format, sector encoding and hue decode.
// The forward (RGB->HSV) selector imports the same package.
package hsv_pkg;
    localparam int N    = 32;
    localparam int FRAC = 15;
    localparam int NSEC = 6;
    localparam int QW   = FRAC + 2;    // magnitude width able to hold ONE
    localparam int IW   = N - FRAC - 1;  // integer-part width

    typedef logic [N-1:0]  word_t;
    typedef logic [QW-1:0] q17_t;
    typedef logic [IW-1:0] ipart_t;

    localparam q17_t ONE = q17_t'(1 << FRAC);

    // Hue sextants, named by the colour ramp each one spans
    typedef enum logic [2:0] {
        SEC_RY = 3'd0,
        SEC_YG = 3'd1,
        SEC_GC = 3'd2,
        SEC_CB = 3'd3,
        SEC_BM = 3'd4,
        SEC_MR = 3'd5
    } sector_e;

    typedef struct packed {
        logic    err;
        sector_e sec;
        q17_t    f;
    } hue_t;

    // Split a sign-magnitude hue into sector, fraction and range error
    function automatic hue_t decode_hue(word_t h);
        hue_t   d;
        ipart_t ip;
        ip    = h[N-2:FRAC];
        d.err = h[N-1] | (ip >= ipart_t'(NSEC));
        d.sec = sector_e'(ip[2:0]);
        d.f   = {2'b00, h[FRAC-1:0]};
        return d;
    endfunction

    // Drop the sign and saturate the magnitude at ONE
    function automatic q17_t clamp_mag(word_t x);
        word_t m;
        m        = x;
        m[N-1]   = 1'b0;
        return (m > word_t'(ONE)) ? ONE : q17_t'(m);
    endfunction
endpackage

// File: rtl/hsv2rgb_sector_if.sv
// HSV in / RGB out stream bundle; slave is the converter, master drives it.
interface hsv2rgb_sector_if;
    import hsv_pkg::*;

    logic  in_valid;
    logic  in_ready;
    word_t H;
    word_t S;
    word_t V;
    logic  out_valid;
    logic  out_ready;
    word_t R;
    word_t G;
    word_t B;
    logic  out_err;

    modport slave (
        input  in_valid, H, S, V, out_ready,
        output in_ready, out_valid, R, G, B, out_err
    );

    modport master (
        output in_valid, H, S, V, out_ready,
        input  in_ready, out_valid, R, G, B, out_err
    );
endinterface

// File: rtl/hsv2rgb_sector_q15_mul.sv
// Unsigned Q1.15 magnitude multiply with truncating shift: (a*b)>>FRAC.
module q15_mul
    import hsv_pkg::*;
(
    input  q17_t a,
    input  q17_t b,
    output q17_t y
);
    assign y = q17_t'((34'(a) * 34'(b)) >> FRAC);
endmodule

// File: rtl/hsv2rgb_sector.sv
// HSV -> RGB: 4-stage pipeline (decode, S*f terms, V products, sector route)
// sharing a single advance enable so a stalled output freezes every stage.
module hsv2rgb_sector
    import hsv_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    hsv2rgb_sector_if.slave  bus
);
    logic    en;

    logic    vld1, vld2, vld3;
    hue_t    hue1;
    q17_t    s1, v1;
    logic    err2, err3;
    sector_e sec2, sec3;
    q17_t    s2, v2, a2, b2;
    q17_t    v3, p3, q3, t3;

    q17_t    nf1, ns2, na2, nb2;
    q17_t    a_nxt, b_nxt, p_nxt, q_nxt, t_nxt;
    q17_t    r_nxt, g_nxt, b_out_nxt;

    assign en           = !bus.out_valid | bus.out_ready;
    assign bus.in_ready = en;

    assign nf1 = ONE - hue1.f;
    assign ns2 = ONE - s2;
    assign na2 = ONE - a2;
    assign nb2 = ONE - b2;

    q15_mul u_mul_a (.a(s1), .b(hue1.f), .y(a_nxt));
    q15_mul u_mul_b (.a(s1), .b(nf1),    .y(b_nxt));
    q15_mul u_mul_p (.a(v2), .b(ns2),    .y(p_nxt));
    q15_mul u_mul_q (.a(v2), .b(na2),    .y(q_nxt));
    q15_mul u_mul_t (.a(v2), .b(nb2),    .y(t_nxt));

    // Route {V,p,q,t} onto R/G/B by sector; out-of-range hue forces black
    always_comb begin
        r_nxt     = '0;
        g_nxt     = '0;
        b_out_nxt = '0;
        if (!err3) begin
            case (sec3)
                SEC_RY: begin r_nxt = v3; g_nxt = t3; b_out_nxt = p3; end
                SEC_YG: begin r_nxt = q3; g_nxt = v3; b_out_nxt = p3; end
                SEC_GC: begin r_nxt = p3; g_nxt = v3; b_out_nxt = t3; end
                SEC_CB: begin r_nxt = p3; g_nxt = q3; b_out_nxt = v3; end
                SEC_BM: begin r_nxt = t3; g_nxt = p3; b_out_nxt = v3; end
                SEC_MR: begin r_nxt = v3; g_nxt = p3; b_out_nxt = q3; end
                default: begin r_nxt = '0; g_nxt = '0; b_out_nxt = '0; end
            endcase
        end
    end

    // Pipeline registers, all advanced together by en
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld1          <= 1'b0;
            hue1          <= '0;
            s1            <= '0;
            v1            <= '0;
            vld2          <= 1'b0;
            err2          <= 1'b0;
            sec2          <= SEC_RY;
            s2            <= '0;
            v2            <= '0;
            a2            <= '0;
            b2            <= '0;
            vld3          <= 1'b0;
            err3          <= 1'b0;
            sec3          <= SEC_RY;
            v3            <= '0;
            p3            <= '0;
            q3            <= '0;
            t3            <= '0;
            bus.out_valid <= 1'b0;
            bus.R         <= '0;
            bus.G         <= '0;
            bus.B         <= '0;
            bus.out_err   <= 1'b0;
        end else if (en) begin
            vld1          <= bus.in_valid;
            hue1          <= decode_hue(bus.H);
            s1            <= clamp_mag(bus.S);
            v1            <= clamp_mag(bus.V);

            vld2          <= vld1;
            err2          <= hue1.err;
            sec2          <= hue1.sec;
            s2            <= s1;
            v2            <= v1;
            a2            <= a_nxt;
            b2            <= b_nxt;

            vld3          <= vld2;
            err3          <= err2;
            sec3          <= sec2;
            v3            <= v2;
            p3            <= p_nxt;
            q3            <= q_nxt;
            t3            <= t_nxt;

            bus.out_valid <= vld3;
            bus.R         <= word_t'(r_nxt);
            bus.G         <= word_t'(g_nxt);
            bus.B         <= word_t'(b_out_nxt);
            bus.out_err   <= err3;
        end
    end
endmodule

// File: tb/tb_hsv2rgb_sector.sv
// Scoreboard bench for hsv2rgb_sector: directed vectors, backpressure, mid-stream reset.
module tb_hsv2rgb_sector;
    import hsv_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hsv2rgb_sector_if bus ();

    hsv2rgb_sector dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] h, s, v, r, g, b;
        logic        err;
    } vec_t;

    typedef struct {
        logic [31:0] r, g, b;
        logic        err;
    } exp_t;

    vec_t vecs [16] = '{
        '{32'h0000_0000, 32'h8000, 32'h8000, 32'h8000, 32'h0000, 32'h0000, 1'b0},
        '{32'h0001_0000, 32'h8000, 32'h8000, 32'h0000, 32'h8000, 32'h0000, 1'b0},
        '{32'h0002_0000, 32'h8000, 32'h8000, 32'h0000, 32'h0000, 32'h8000, 1'b0},
        '{32'h0000_C000, 32'h8000, 32'h8000, 32'h4000, 32'h8000, 32'h0000, 1'b0},
        '{32'h0002_8000, 32'h8000, 32'h8000, 32'h8000, 32'h0000, 32'h8000, 1'b0},
        '{32'h0001_8000, 32'h0000, 32'h4000, 32'h4000, 32'h4000, 32'h4000, 1'b0},
        '{32'h0001_8000, 32'h9000, 32'h4000, 32'h0000, 32'h4000, 32'h4000, 1'b0},
        '{32'h0003_0000, 32'h8000, 32'h8000, 32'h0000, 32'h0000, 32'h0000, 1'b1},
        '{32'h8000_4000, 32'h8000, 32'h8000, 32'h0000, 32'h0000, 32'h0000, 1'b1},
        '{32'h7FFF_8000, 32'h8000, 32'h8000, 32'h0000, 32'h0000, 32'h0000, 1'b1},
        '{32'h0000_4000, 32'h8000, 32'h4000, 32'h4000, 32'h2000, 32'h0000, 1'b0},
        '{32'h0001_4000, 32'h4000, 32'h8000, 32'h4000, 32'h8000, 32'h6000, 1'b0},
        '{32'h0000_2AAA, 32'h7FFF, 32'h7FFF, 32'h7FFF, 32'h2AAA, 32'h0000, 1'b0},
        '{32'h0000_C000, 32'h8000, 32'h0000, 32'h0000, 32'h0000, 32'h0000, 1'b0},
        '{32'h0000_0000, 32'h8000, 32'h8000_8000, 32'h8000, 32'h0000, 32'h0000, 1'b0},
        '{32'h0000_8000, 32'h8000, 32'h8000, 32'h8000, 32'h8000, 32'h0000, 1'b0}
    };

    exp_t exp_q [$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic fail_bound(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=handshake", name);
    endtask

    // Present one pixel; push its expectation once the handshake is certain
    task automatic send(input vec_t t);
        int unsigned n;
        exp_t        e;
        n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.H        = t.h;
        bus.S        = t.s;
        bus.V        = t.v;
        #1;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!bus.in_ready) begin
            fail_bound("in_ready_timeout");
        end else begin
            e.r   = t.r;
            e.g   = t.g;
            e.b   = t.b;
            e.err = t.err;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int unsigned n;
        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() > 0) fail_bound("drain_timeout");
    endtask

    // Monitor: pops on every output transfer, checks hold and in_ready during stalls
    initial begin
        exp_t        e;
        logic        held;
        logic [31:0] hr, hg, hb;
        held = 1'b0;
        hr = '0; hg = '0; hb = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    check("hold_valid", {31'b0, bus.out_valid}, 32'd1);
                    check("hold_R", bus.R, hr);
                    check("hold_G", bus.G, hg);
                    check("hold_B", bus.B, hb);
                end
                held = 1'b0;
                if (bus.out_valid) begin
                    if (!bus.out_ready) begin
                        check("stall_in_ready", {31'b0, bus.in_ready}, 32'd0);
                        held = 1'b1;
                        hr = bus.R;
                        hg = bus.G;
                        hb = bus.B;
                    end else if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_output actual=R%h G%h B%h required=none",
                                 bus.R, bus.G, bus.B);
                    end else begin
                        e = exp_q.pop_front();
                        check("R", bus.R, e.r);
                        check("G", bus.G, e.g);
                        check("B", bus.B, e.b);
                        check("out_err", {31'b0, bus.out_err}, {31'b0, e.err});
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.H         = '0;
        bus.S         = '0;
        bus.V         = '0;
        bus.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        #1;
        check("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("reset_R", bus.R, 32'd0);
        check("reset_G", bus.G, 32'd0);
        check("reset_B", bus.B, 32'd0);
        check("reset_out_err", {31'b0, bus.out_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("in_ready_after_reset", {31'b0, bus.in_ready}, 32'd1);

        // Directed vectors back to back
        for (int i = 0; i < 16; i++) send(vecs[i]);
        idle();
        drain();

        // Six pixels with a 5-cycle output stall mid-stream
        fork
            begin
                for (int i = 0; i < 6; i++) send(vecs[i]);
                idle();
            end
            begin
                repeat (6) @(negedge clk);
                bus.out_ready = 1'b0;
                repeat (5) @(negedge clk);
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // Reset while pixels are in flight and one is on the output
        for (int i = 0; i < 3; i++) send(vecs[i]);
        idle();
        @(negedge clk);
        @(negedge clk);
        #3;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("midreset_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("midreset_R", bus.R, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("midreset_in_ready", {31'b0, bus.in_ready}, 32'd1);
        repeat (10) @(negedge clk);
        #1;
        check("no_stale_output", {31'b0, bus.out_valid}, 32'd0);

        // Pipeline still works after the reset
        send(vecs[3]);
        idle();
        drain();
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
